// File: rtl/sdpram_bist.sv
// sdpram_bist: fill/readback self-test engine for one single-clock SDP RAM.
// Writes a pattern to every address, reads it back and compares at the RAM read latency.
module sdpram_bist #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 34,
  parameter int OUTPUT_REG    = 0,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               mode,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data
);
  localparam int RD_LAT = 1 + OUTPUT_REG;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);
  localparam logic [CW-1:0] DRAIN_LEN = CW'(RD_LAT);
  localparam logic [DATA_WIDTH-1:0] CHK = DATA_WIDTH'({(DATA_WIDTH + 1) / 2{2'b01}});

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_FINISH} state_t;

  state_t                   r_state, w_nxt;
  logic [CW-1:0]            r_cnt, w_cnt_inc;
  logic [ADDR_WIDTH-1:0]    w_addr, r_rd_hold, r_first;
  logic [1:0]               r_mode;
  logic                     w_term, w_acc, w_mm, r_pass;
  logic [ERR_CNT_WIDTH-1:0] r_err;
  logic                     r_vld [RD_LAT];
  logic [DATA_WIDTH-1:0]    r_exp [RD_LAT];
  logic [ADDR_WIDTH-1:0]    r_ea  [RD_LAT];

  // Mode 3 shares the mode-0 pattern so it can verify data left by a previous run.
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
    return m == 2'd1 ? DATA_WIDTH'(a) : m == 2'd2 ? (a[0] ? ~CHK : CHK) : ~(DATA_WIDTH'(a));
  endfunction

  always_comb begin
    w_cnt_inc = r_cnt + 1'b1;
    w_addr = r_cnt[ADDR_WIDTH-1:0];
    w_term = w_cnt_inc == DEPTH;
    w_acc = r_state == S_IDLE && start;
    w_mm = r_vld[RD_LAT-1] && mem_rd_data != r_exp[RD_LAT-1];
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = start ? (mode == 2'd3 ? S_READ : S_WRITE) : S_IDLE;
      S_WRITE: w_nxt = w_term ? S_READ : S_WRITE;
      S_READ:  w_nxt = w_term ? S_DRAIN : S_READ;
      S_DRAIN: w_nxt = w_cnt_inc == DRAIN_LEN ? S_FINISH : S_DRAIN;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_mode <= '0;
      r_rd_hold <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt <= (r_state == S_IDLE || w_nxt != r_state) ? '0 : w_cnt_inc;
      if (w_acc) r_mode <= mode;
      if (r_state == S_READ) r_rd_hold <= w_addr;
    end
  end

  // Valid flag, expected data and address ride a pipe as long as the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) r_vld[i] <= 1'b0;
    end else begin
      r_vld[0] <= r_state == S_READ;
      for (int i = 1; i < RD_LAT; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_exp[0] <= pat(r_mode, w_addr);
    r_ea[0] <= w_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      r_exp[i] <= r_exp[i-1];
      r_ea[i] <= r_ea[i-1];
    end
  end

  // The last beat is compared on the edge that enters FINISH, so pass folds it in directly.
  always_ff @(posedge clk) begin
    if (rst || w_acc) begin
      r_pass <= 1'b0;
      r_err <= '0;
      r_first <= '0;
    end else begin
      if (w_mm && !(&r_err)) r_err <= r_err + 1'b1;
      if (w_mm && r_err == '0) r_first <= r_ea[RD_LAT-1];
      if (w_nxt == S_FINISH) r_pass <= r_err == '0 && !w_mm;
    end
  end

  assign busy = r_state == S_WRITE || r_state == S_READ || r_state == S_DRAIN;
  assign done = r_state == S_FINISH;
  assign pass = r_pass;
  assign err_cnt = r_err;
  assign first_err_addr = r_first;
  assign mem_wr_en = r_state == S_WRITE;
  assign mem_wr_addr = mem_wr_en ? w_addr : '0;
  assign mem_wr_data = mem_wr_en ? pat(r_mode, w_addr) : '0;
  assign mem_rd_addr = r_state == S_READ ? w_addr : r_rd_hold;
endmodule

// File: tb/tb_sdpram_bist.sv
// tb_sdpram_bist: directed table-driven bench for sdpram_bist with behavioural RAM models.
module tb_sdpram_bist;
  logic clk = 1'b0, rst = 1'b1, sel = 1'b0;
  always #5 clk = ~clk;

  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] mode0 = 2'd0, mode1 = 2'd0;
  logic busy0, done0, pass0, we0, busy1, done1, pass1, we1;
  logic [2:0] err0, err1;
  logic [7:0] fe0, wa0, ra0, fe1, wa1, ra1;
  logic [33:0] wd0, rd0, wd1, rd1;

  sdpram_bist #(.OUTPUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mode(mode0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_err_addr(fe0), .mem_wr_en(we0), .mem_wr_addr(wa0), .mem_wr_data(wd0),
    .mem_rd_addr(ra0), .mem_rd_data(rd0));

  sdpram_bist #(.OUTPUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_addr(fe1), .mem_wr_en(we1), .mem_wr_addr(wa1), .mem_wr_data(wd1),
    .mem_rd_addr(ra1), .mem_rd_data(rd1));

  // RAM models: fault injection on the read path of ram 0, selectable latency on ram 1.
  logic [33:0] mem0 [256];
  logic [33:0] mem1 [256];
  logic [33:0] q0, q1a, q1b;
  int flt = 0, lat1 = 2;

  function automatic logic [33:0] fault(input logic [33:0] v, input logic [7:0] a);
    case (flt)
      1: return a == 8'h10 ? v ^ 34'h20 : v;
      2: return v & ~34'h2;
      3: return v | 34'h2;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0;
    q0 <= fault(mem0[ra0], ra0);
    if (we1) mem1[wa1] <= wd1;
    q1a <= mem1[ra1];
    q1b <= q1a;
  end
  assign rd0 = q0;
  assign rd1 = lat1 == 2 ? q1b : q1a;

  logic b, d, p;
  logic [2:0] e;
  logic [7:0] f;
  assign b = sel ? busy1 : busy0;
  assign d = sel ? done1 : done0;
  assign p = sel ? pass1 : pass0;
  assign e = sel ? err1 : err0;
  assign f = sel ? fe1 : fe0;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_start(input logic v, input logic [1:0] m);
    if (sel) begin
      start1 = v;
      mode1 = m;
    end else begin
      start0 = v;
      mode0 = m;
    end
  endtask

  // cyc 1 is the cycle start is held high; done is awaited with a cycle budget.
  task automatic run(input logic [1:0] m, input int poke, output int cyc);
    @(negedge clk);
    drive_start(1'b1, m);
    cyc = 1;
    @(negedge clk);
    drive_start(1'b0, m);
    cyc = 2;
    chk("busy_after_start", longint'(b), 1);
    while (!d && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      drive_start(cyc == poke, cyc == poke ? 2'd3 : m);
    end
    chk("done_seen", longint'(d), 1);
  endtask

  task automatic result(input string nm, input int cyc, input int ecyc, input logic ep,
                        input logic [2:0] ee, input logic [7:0] ef);
    chk({nm, "_done_cycle"}, longint'(cyc), longint'(ecyc));
    @(negedge clk);
    chk({nm, "_done_width"}, longint'(d), 0);
    chk({nm, "_busy_idle"}, longint'(b), 0);
    chk({nm, "_pass"}, longint'(p), longint'(ep));
    chk({nm, "_err_cnt"}, longint'(e), longint'(ee));
    chk({nm, "_first_err"}, longint'(f), longint'(ef));
  endtask

  typedef struct {
    logic [1:0]  mode;
    int          flt;
    int          cyc;
    logic        pass;
    logic [2:0]  err;
    logic [7:0]  fe;
    logic [33:0] d0;
    logic [33:0] dl;
  } vec_t;
  vec_t tv [8];

  initial begin
    int cyc, k, nd;
    tv[0] = '{2'd0, 0, 515, 1'b1, 3'd0, 8'h00, 34'h3_FFFF_FFFF, 34'h3_FFFF_FF00};
    tv[1] = '{2'd0, 1, 515, 1'b0, 3'd1, 8'h10, 34'h3_FFFF_FFFF, 34'h3_FFFF_FF00};
    tv[2] = '{2'd2, 2, 515, 1'b0, 3'd7, 8'h01, 34'h1_5555_5555, 34'h2_AAAA_AAAA};
    tv[3] = '{2'd2, 3, 515, 1'b0, 3'd7, 8'h00, 34'h1_5555_5555, 34'h2_AAAA_AAAA};
    tv[4] = '{2'd1, 0, 515, 1'b1, 3'd0, 8'h00, 34'h0_0000_0000, 34'h0_0000_00FF};
    tv[5] = '{2'd3, 0, 259, 1'b0, 3'd7, 8'h00, 34'h0_0000_0000, 34'h0_0000_00FF};
    tv[6] = '{2'd0, 0, 515, 1'b1, 3'd0, 8'h00, 34'h3_FFFF_FFFF, 34'h3_FFFF_FF00};
    tv[7] = '{2'd3, 0, 259, 1'b1, 3'd0, 8'h00, 34'h3_FFFF_FFFF, 34'h3_FFFF_FF00};

    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy0), 0);
    chk("rst_done", longint'(done0), 0);
    chk("rst_wr_en", longint'(we0), 0);
    chk("rst_rd_addr", longint'(ra0), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      flt = tv[i].flt;
      run(tv[i].mode, 0, cyc);
      result($sformatf("vec%0d", i), cyc, tv[i].cyc, tv[i].pass, tv[i].err, tv[i].fe);
      chk($sformatf("vec%0d_mem0", i), longint'(mem0[0]), longint'(tv[i].d0));
      chk($sformatf("vec%0d_mem255", i), longint'(mem0[255]), longint'(tv[i].dl));
    end

    // Abort a mode-0 run at write address 100.
    flt = 0;
    @(negedge clk);
    drive_start(1'b1, 2'd0);
    @(negedge clk);
    drive_start(1'b0, 2'd0);
    k = 0;
    while (!(we0 && wa0 == 8'd100) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_wr_addr100", longint'(we0 && wa0 == 8'd100), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", longint'(busy0), 0);
    chk("abort_done", longint'(done0), 0);
    chk("abort_pass", longint'(pass0), 0);
    chk("abort_err", longint'(err0), 0);
    chk("abort_first", longint'(fe0), 0);
    chk("abort_wr_en", longint'(we0), 0);
    chk("abort_wr_addr", longint'(wa0), 0);
    chk("abort_wr_data", longint'(wd0), 0);
    chk("abort_rd_addr", longint'(ra0), 0);
    rst = 1'b0;
    nd = 0;
    repeat (600) begin
      @(negedge clk);
      nd += int'(done0);
    end
    chk("abort_no_done", longint'(nd), 0);

    // Full run after abort, with a start pulse mid-run that must be ignored.
    run(2'd0, 50, cyc);
    result("after_abort", cyc, 515, 1'b1, 3'd0, 8'h00);

    sel = 1'b1;
    lat1 = 2;
    run(2'd1, 0, cyc);
    result("oreg_lat2", cyc, 516, 1'b1, 3'd0, 8'h00);
    lat1 = 1;
    run(2'd1, 0, cyc);
    result("oreg_lat1", cyc, 516, 1'b0, 3'd7, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
